// File: rtl/tseq_pkg.sv
// Shared types and constants for the timing_seq beat sequencer.
// Optional counter build is selected by TSEQ_CYCLE_CNT_EN (see timing_seq.sv).
package tseq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PH_T1 = 2'd0,
        PH_T2 = 2'd1,
        PH_T3 = 2'd2,
        PH_T4 = 2'd3
    } phase_t;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_USTEP = 2'b01;
    localparam logic [1:0] MODE_ISTEP = 2'b10;

    localparam int CNT_W = 16;

    // One strobe bit per phase: bit 0 is t1, bit 3 is t4.
    function automatic logic [3:0] phase_onehot(phase_t ph);
        return 4'b0001 << ph;
    endfunction

endpackage

// File: rtl/phase_div.sv
// Modulo-T_LEN clock divider; tc marks the last clock of the current phase.
// Cleared by reset or by clr (sequencer entering RUN), counts only while en.
module phase_div #(
    parameter int T_LEN = 1
) (
    input  logic clk,
    input  logic nclr,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [3:0] cnt_q;

    assign tc = (cnt_q == 4'(T_LEN - 1));

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!nclr || clr) begin
            cnt_q <= 4'd0;
        end else if (en) begin
            cnt_q <= tc ? 4'd0 : cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/timing_seq.sv
// Beat sequencer: four one-hot phase strobes t1..t4 with run/stop/step control.
// Define TSEQ_CYCLE_CNT_EN to build the 16-bit micro-cycle counter; otherwise ucycle_cnt is 0.
module timing_seq
    import tseq_pkg::*;
#(
    parameter int T_LEN = 1
) (
    input  logic             clk,
    input  logic             nclr,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             p1,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             t4,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] ucycle_cnt
);

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic       stop_q, stop_d;
    logic       done_d;
    logic       div_clr, div_en, div_tc;
    logic [3:0] t_q;
    logic       running_q, done_q;

    phase_div #(.T_LEN(T_LEN)) u_div (
        .clk  (clk),
        .nclr (nclr),
        .clr  (div_clr),
        .en   (div_en),
        .tc   (div_tc)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        div_clr = 1'b0;
        div_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    phase_d = PH_T1;
                    div_clr = 1'b1;
                end
            end
            RUN: begin
                div_en = 1'b1;
                if (stop) stop_d = 1'b1;
                if (div_tc) begin
                    if (phase_q == PH_T4) begin
                        // Micro-cycle boundary: the only point where stop, mode and p1 act.
                        phase_d = PH_T1;
                        if (stop_q || stop || mode == MODE_USTEP ||
                            (mode == MODE_ISTEP && p1)) begin
                            state_d = IDLE;
                            stop_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        phase_d = phase_t'(phase_q + 2'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next-state decode, so they line up with
    // the state register without any input-to-output combinational path.
    always_ff @(posedge clk) begin
        if (!nclr) begin
            state_q   <= IDLE;
            phase_q   <= PH_T1;
            stop_q    <= 1'b0;
            t_q       <= 4'b0000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            stop_q    <= stop_d;
            t_q       <= (state_d == RUN) ? phase_onehot(phase_d) : 4'b0000;
            running_q <= (state_d == RUN);
            done_q    <= done_d;
        end
    end

    assign t1      = t_q[0];
    assign t2      = t_q[1];
    assign t3      = t_q[2];
    assign t4      = t_q[3];
    assign running = running_q;
    assign done    = done_q;

`ifdef TSEQ_CYCLE_CNT_EN
    logic             cyc_end;
    logic [CNT_W-1:0] cnt_q;

    assign cyc_end = (state_q == RUN) && (phase_q == PH_T4) && div_tc;

    always_ff @(posedge clk) begin
        if (!nclr) begin
            cnt_q <= '0;
        end else if (cyc_end) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ucycle_cnt = cnt_q;
`else
    assign ucycle_cnt = '0;
`endif

endmodule

// File: tb/tb_timing_seq.sv
// Self-checking bench for timing_seq: two instances (T_LEN=1 and T_LEN=2) share stimulus
// and are compared every clock against a clock-index reference model.
module tb_timing_seq;

`ifdef TSEQ_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nclr, start, stop, p1;
    logic [1:0] mode;
    logic t1_a, t2_a, t3_a, t4_a, running_a, done_a;
    logic t1_b, t2_b, t3_b, t4_b, running_b, done_b;
    logic [15:0] cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    timing_seq #(.T_LEN(1)) dut_a (
        .clk(clk), .nclr(nclr), .start(start), .stop(stop), .mode(mode), .p1(p1),
        .t1(t1_a), .t2(t2_a), .t3(t3_a), .t4(t4_a),
        .running(running_a), .done(done_a), .ucycle_cnt(cnt_a)
    );

    timing_seq #(.T_LEN(2)) dut_b (
        .clk(clk), .nclr(nclr), .start(start), .stop(stop), .mode(mode), .p1(p1),
        .t1(t1_b), .t2(t2_b), .t3(t3_b), .t4(t4_b),
        .running(running_b), .done(done_b), .ucycle_cnt(cnt_b)
    );

    // Reference model: position within a micro-cycle is a plain clock index 0..4*T_LEN-1.
    int          tl[2] = '{1, 2};
    bit          m_run[2];
    int          m_idx[2];
    bit          m_stopl[2];
    bit          m_done[2];
    logic [15:0] m_cnt[2];

    task automatic model_step(int k);
        bit last;
        if (!nclr) begin
            m_run[k] = 0; m_idx[k] = 0; m_stopl[k] = 0; m_done[k] = 0; m_cnt[k] = 16'h0;
        end else if (!m_run[k]) begin
            m_done[k] = 0;
            if (start && !stop) begin
                m_run[k] = 1; m_idx[k] = 0;
            end
        end else begin
            m_done[k] = 0;
            last = (m_idx[k] == 4 * tl[k] - 1);
            if (last) begin
                if (CNT_EN) m_cnt[k] = m_cnt[k] + 16'd1;
                m_idx[k] = 0;
                if (m_stopl[k] || stop || mode == 2'b01 || (mode == 2'b10 && p1)) begin
                    m_run[k] = 0; m_stopl[k] = 0; m_done[k] = 1;
                end
            end else begin
                m_idx[k] = m_idx[k] + 1;
                if (stop) m_stopl[k] = 1;
            end
        end
    endtask

    function automatic logic [21:0] exp_vec(int k);
        logic [3:0] strobes;
        strobes = m_run[k] ? (4'b0001 << (m_idx[k] / tl[k])) : 4'b0000;
        return {strobes, m_run[k], m_done[k], m_cnt[k]};
    endfunction

    function automatic logic [21:0] dut_vec(int k);
        if (k == 0) return {t4_a, t3_a, t2_a, t1_a, running_a, done_a, cnt_a};
        return {t4_b, t3_b, t2_b, t1_b, running_b, done_b, cnt_b};
    endfunction

    // Advance one clock: model consumes the inputs held across the edge, DUT sampled #1 later.
    task automatic cycle();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nclr = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00; p1 = 1'b0;
        cycle();
        cycle();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dut_vec(k) !== 22'h0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got %h expected %h", k, dut_vec(k), 22'h0);
            end
        end
        nclr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL reset_idle inst%0d clk%0d: got %h expected %h", k, c, dut_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_continuous();
        logic [3:0] seen;
        mode = 2'b00;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            seen = {t4_a, t3_a, t2_a, t1_a};
            n_tests++;
            if (seen !== (4'b0001 << (c % 4))) begin
                n_fail++;
                $display("FAIL cont_phase clk%0d: got %b expected %b", c, seen, 4'b0001 << (c % 4));
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL cont inst%0d clk%0d: got %h expected %h", k, c, dut_vec(k), exp_vec(k));
                end
            end
            cycle();
        end
        n_tests++;
        if (cnt_a !== (CNT_EN ? 16'd2 : 16'd0)) begin
            n_fail++;
            $display("FAIL cont_count: got %0d expected %0d", cnt_a, CNT_EN ? 2 : 0);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL cont_stop inst%0d clk%0d: got %h expected %h", k, c, dut_vec(k), exp_vec(k));
                end
            end
        end
        n_tests++;
        if (running_a !== 1'b0 || running_b !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_idle: got running %b%b expected 00", running_a, running_b);
        end
    endtask

    task automatic test_ustep();
        int n_t1 = 0, n_done = 0;
        mode = 2'b01;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            n_t1 += int'(t1_b);
            n_done += int'(done_b);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL ustep inst%0d clk%0d: got %h expected %h", k, c, dut_vec(k), exp_vec(k));
                end
            end
            if (c == 8) begin
                n_tests++;
                if (done_b !== 1'b1 || running_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ustep_end: got done %b running %b expected 1 0", done_b, running_b);
                end
            end
            cycle();
        end
        n_tests++;
        if (n_t1 !== 2 || n_done !== 1) begin
            n_fail++;
            $display("FAIL ustep_counts: got t1 %0d done %0d expected 2 1", n_t1, n_done);
        end
    endtask

    task automatic test_istep();
        int n_cyc = 0, n_done = 0;
        mode = 2'b10;
        p1 = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c == 8) p1 = 1'b1;
            n_cyc += int'(t4_a);
            n_done += int'(done_a);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL istep inst%0d clk%0d: got %h expected %h", k, c, dut_vec(k), exp_vec(k));
                end
            end
            cycle();
        end
        p1 = 1'b0;
        n_tests++;
        if (n_cyc !== 3 || n_done !== 1) begin
            n_fail++;
            $display("FAIL istep_counts: got cycles %0d done %0d expected 3 1", n_cyc, n_done);
        end
    endtask

    task automatic test_stop();
        int n_t4 = 0, n_done = 0, n_strobe = 0;
        mode = 2'b00;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 9; c++) begin
            n_t4 += int'(t4_a);
            cycle();
        end
        n_tests++;
        if (t2_a !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_setup: got t2 %b expected 1", t2_a);
        end
        stop = 1'b1;
        for (int c = 0; c < 16; c++) begin
            n_t4 += int'(t4_a);
            n_done += int'(done_a);
            cycle();
            stop = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL stop inst%0d clk%0d: got %h expected %h", k, c, dut_vec(k), exp_vec(k));
                end
            end
        end
        n_tests++;
        if (n_t4 !== 3 || n_done !== 1) begin
            n_fail++;
            $display("FAIL stop_counts: got t4 %0d done %0d expected 3 1", n_t4, n_done);
        end
        start = 1'b1;
        stop = 1'b1;
        cycle();
        start = 1'b0;
        stop = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_strobe += int'(t1_a | t2_a | t3_a | t4_a | t1_b | t2_b | t3_b | t4_b);
            cycle();
        end
        n_tests++;
        if (n_strobe !== 0) begin
            n_fail++;
            $display("FAIL start_stop_same: got %0d strobe clocks expected 0", n_strobe);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0, n_done = 0;
        mode = 2'b00;
        start = 1'b1;
        cycle();
        start = 1'b0;
        while (t3_b !== 1'b1 && guard < 20) begin
            cycle();
            guard++;
        end
        n_tests++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got no t3 within %0d clocks expected t3", guard);
        end
        nclr = 1'b0;
        cycle();
        nclr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dut_vec(k) !== 22'h0) begin
                n_fail++;
                $display("FAIL reset_mid inst%0d: got %h expected %h", k, dut_vec(k), 22'h0);
            end
        end
        for (int c = 0; c < 6; c++) begin
            cycle();
            n_done += int'(done_a | done_b);
        end
        n_tests++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_done: got %0d done pulses expected 0", n_done);
        end
    endtask

    task automatic test_counter();
`ifdef TSEQ_CYCLE_CNT_EN
        dut_a.cnt_q = 16'hFFFF;
        dut_b.cnt_q = 16'hFFFF;
        m_cnt[0] = 16'hFFFF;
        m_cnt[1] = 16'hFFFF;
        mode = 2'b01;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 12; c++) cycle();
        n_tests++;
        if (cnt_a !== 16'h0000 || cnt_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL cnt_wrap: got %h %h expected 0000 0000", cnt_a, cnt_b);
        end
`else
        mode = 2'b00;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 20; c++) cycle();
        n_tests++;
        if (cnt_a !== 16'h0000 || cnt_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL cnt_absent: got %h %h expected 0000 0000", cnt_a, cnt_b);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        for (int c = 0; c < 10; c++) cycle();
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            start = ($urandom % 4) == 0;
            stop  = ($urandom % 20) == 0;
            p1    = ($urandom % 3) == 0;
            if (($urandom % 10) == 0) mode = 2'($urandom % 4);
            nclr  = ($urandom % 150) != 0;
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random inst%0d clk%0d: got %h expected %h", k, c, dut_vec(k), exp_vec(k));
                end
            end
        end
        nclr = 1'b1; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_ustep();
        test_istep();
        test_stop();
        test_reset_mid();
        test_counter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
